// File: rtl/alu_pkg.sv
// Shared types and field map for the ALU scheduler slice.
// Build option: ALU_SCHED_RR_EN selects round-robin arbitration.
package alu_pkg;

    localparam int INSTR_LENGTH = 12;
    localparam int OPERAND_W    = 4;
    localparam int OPCODE_W     = 3;

    localparam int FUNCT_BIT = 11;
    localparam int A_MSB     = 10;
    localparam int A_LSB     = 7;
    localparam int B_MSB     = 6;
    localparam int B_LSB     = 3;
    localparam int OP_MSB    = 2;
    localparam int OP_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, ALU and response signals of the ALU scheduler.
// master = scheduler side, slave = requesters/ALU/consumer side.
interface alu_scheduler_if;
    import alu_pkg::*;

    logic                    req0_valid;
    logic [INSTR_LENGTH-1:0] req0_instr;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [INSTR_LENGTH-1:0] req1_instr;
    logic                    req1_ready;

    logic [OPERAND_W-1:0]    alu_a;
    logic [OPERAND_W-1:0]    alu_b;
    logic [OPCODE_W-1:0]     alu_opcode;
    logic                    alu_funct;
    logic                    alu_exec_en;
    logic [OPERAND_W-1:0]    alu_out;
    logic                    alu_cb;

    logic                    rsp_valid;
    req_id_t                 rsp_id;
    logic [OPERAND_W-1:0]    rsp_result;
    logic                    rsp_cb;
    logic                    rsp_ready;

    modport master (
        input  req0_valid, req0_instr,
        output req0_ready,
        input  req1_valid, req1_instr,
        output req1_ready,
        output alu_a, alu_b, alu_opcode,
        output alu_funct, alu_exec_en,
        input  alu_out, alu_cb,
        output rsp_valid, rsp_id,
        output rsp_result, rsp_cb,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_instr,
        input  req0_ready,
        output req1_valid, req1_instr,
        input  req1_ready,
        input  alu_a, alu_b, alu_opcode,
        input  alu_funct, alu_exec_en,
        output alu_out, alu_cb,
        input  rsp_valid, rsp_id,
        input  rsp_result, rsp_cb,
        output rsp_ready
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-input grant logic for the ALU scheduler.
// ALU_SCHED_RR_EN: round-robin on contention, else req0 has priority.
module alu_rr_arb2
    import alu_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output logic    gnt0,
    output logic    gnt1
);

    // Pick at most one requester; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef ALU_SCHED_RR_EN
        if (valid0 && valid1) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
`else
        gnt0 = valid0;
        gnt1 = valid1 & ~valid0;
        if (last_grant) begin
            gnt0 = valid0;
        end
`endif
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two instruction requesters.
// Build option: ALU_SCHED_RR_EN (round-robin instead of fixed priority).
module alu_scheduler
    import alu_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    alu_scheduler_if.master bus
);

    sched_state_t            state_q, state_d;
    logic [INSTR_LENGTH-1:0] instr_q, instr_d;
    req_id_t                 id_q, id_d;
    req_id_t                 last_grant_q, last_grant_d;
    logic [OPERAND_W-1:0]    result_q, result_d;
    logic                    cb_q, cb_d;

    logic gnt0;
    logic gnt1;
    logic idle;

    alu_rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign idle = (state_q == IDLE);

    // Ready is a pure function of valid while idle; forced low in reset.
    assign bus.req0_ready = reset_n & idle & gnt0;
    assign bus.req1_ready = reset_n & idle & gnt1;

    assign bus.alu_a       = instr_q[A_MSB:A_LSB];
    assign bus.alu_b       = instr_q[B_MSB:B_LSB];
    assign bus.alu_opcode  = instr_q[OP_MSB:OP_LSB];
    assign bus.alu_funct   = instr_q[FUNCT_BIT];
    assign bus.alu_exec_en = (state_q == EXEC);

    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cb     = cb_q;

    // Next-state: issue on grant, capture ALU in EXEC, wait out RESP.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        cb_d         = cb_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    instr_d      = gnt1 ? bus.req1_instr
                                        : bus.req0_instr;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = bus.alu_out;
                cb_d     = bus.alu_cb;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            cb_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            cb_q         <= cb_d;
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed scoreboard bench for alu_scheduler with an adder ALU stub.
// Expected grant order follows ALU_SCHED_RR_EN when defined.
module tb_alu_scheduler;
    import alu_pkg::*;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic       cb;
    } exp_t;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    alu_scheduler_if u_if ();

    alu_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.master)
    );

    // ALU stub: 4-bit add with carry out.
    assign {u_if.alu_cb, u_if.alu_out} =
        {1'b0, u_if.alu_a} + {1'b0, u_if.alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic push(logic id, logic [3:0] r, logic c);
        exp_t e;
        e.id  = id;
        e.res = r;
        e.cb  = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++)
            @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    // Monitor: every accepted response must match the queue head.
    always @(negedge clk) begin
        if (reset_n && u_if.rsp_valid && u_if.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", u_if.rsp_id, e.id);
                chk("rsp_result", u_if.rsp_result, e.res);
                chk("rsp_cb", u_if.rsp_cb, e.cb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        tests = 0;
        fails = 0;

        // 1: reset with both requesters valid
        reset_n         = 1'b0;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h053;
        u_if.req1_valid = 1'b1;
        u_if.req1_instr = 12'h788;
        u_if.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready0", u_if.req0_ready, 0);
        chk("rst_ready1", u_if.req1_ready, 0);
        chk("rst_exec_en", u_if.alu_exec_en, 0);
        chk("rst_alu_a", u_if.alu_a, 0);
        chk("rst_alu_b", u_if.alu_b, 0);
        chk("rst_alu_op", u_if.alu_opcode, 0);
        chk("rst_alu_funct", u_if.alu_funct, 0);
        chk("rst_rsp_valid", u_if.rsp_valid, 0);
        chk("rst_rsp_id", u_if.rsp_id, 0);
        chk("rst_rsp_result", u_if.rsp_result, 0);
        chk("rst_rsp_cb", u_if.rsp_cb, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("first_gnt0", u_if.req0_ready, 1);
        chk("first_gnt1", u_if.req1_ready, 0);
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;

        // 2: single request from req0
        u_if.rsp_ready = 1'b1;
        push(1'b0, 4'hA, 1'b0);
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h053;
        @(negedge clk);
        chk("single_ready0", u_if.req0_ready, 1);
        @(posedge clk);
        #1 u_if.req0_valid = 1'b0;
        @(negedge clk);
        chk("single_exec_en", u_if.alu_exec_en, 1);
        chk("single_alu_a", u_if.alu_a, 4'h0);
        chk("single_alu_b", u_if.alu_b, 4'hA);
        chk("single_alu_op", u_if.alu_opcode, 3'd3);
        chk("single_alu_funct", u_if.alu_funct, 0);
        chk("single_early_rsp", u_if.rsp_valid, 0);
        @(negedge clk);
        chk("single_exec_off", u_if.alu_exec_en, 0);
        chk("single_rsp_valid", u_if.rsp_valid, 1);
        @(negedge clk);
        chk("single_rsp_done", u_if.rsp_valid, 0);

        // single request from req1, funct set, carry out
        push(1'b1, 4'h2, 1'b1);
        @(posedge clk);
        #1;
        u_if.req1_valid = 1'b1;
        u_if.req1_instr = 12'hCCD;
        @(negedge clk);
        chk("r1_ready1", u_if.req1_ready, 1);
        @(posedge clk);
        #1 u_if.req1_valid = 1'b0;
        @(negedge clk);
        chk("r1_alu_a", u_if.alu_a, 4'h9);
        chk("r1_alu_b", u_if.alu_b, 4'h9);
        chk("r1_alu_op", u_if.alu_opcode, 3'd5);
        chk("r1_alu_funct", u_if.alu_funct, 1);
        drain();

        // 3: continuous contention, a=15 b=1
`ifdef ALU_SCHED_RR_EN
        push(1'b0, 4'h0, 1'b1);
        push(1'b1, 4'h0, 1'b1);
        push(1'b0, 4'h0, 1'b1);
        push(1'b1, 4'h0, 1'b1);
`else
        repeat (4) push(1'b0, 4'h0, 1'b1);
`endif
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h788;
        u_if.req1_valid = 1'b1;
        u_if.req1_instr = 12'h789;
        hs = 0;
        for (int c = 0; c < 40 && hs < 4; c++) begin
            @(negedge clk);
            if (u_if.req0_ready || u_if.req1_ready) begin
                chk("cont_onehot",
                    u_if.req0_ready ^ u_if.req1_ready, 1);
                hs++;
            end
        end
        chk("cont_handshakes", hs, 4);
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        drain();

        // 4 + 6: backpressure while req1 wiggles its instruction
        push(1'b0, 4'h7, 1'b0);
        @(posedge clk);
        #1;
        u_if.rsp_ready  = 1'b0;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h1A5;
        @(negedge clk);
        chk("bp_ready0", u_if.req0_ready, 1);
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b1;
        u_if.req1_instr = 12'h053;
        @(negedge clk);
        chk("bp_exec_ready1", u_if.req1_ready, 0);
        @(posedge clk);
        #1 u_if.req1_instr = 12'h788;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", u_if.rsp_valid, 1);
            chk("bp_rsp_id", u_if.rsp_id, 0);
            chk("bp_rsp_result", u_if.rsp_result, 4'h7);
            chk("bp_rsp_cb", u_if.rsp_cb, 0);
            chk("bp_ready0", u_if.req0_ready, 0);
            chk("bp_ready1", u_if.req1_ready, 0);
            chk("bp_exec_en", u_if.alu_exec_en, 0);
            @(posedge clk);
            #1;
            u_if.req1_instr = (i % 2 == 0) ? 12'h053
                                           : 12'h788;
        end
        u_if.req1_instr = 12'h4CD;
        u_if.rsp_ready  = 1'b1;
        push(1'b1, 4'h2, 1'b1);
        @(negedge clk);
        chk("bp_release_valid", u_if.rsp_valid, 1);
        @(negedge clk);
        chk("bp_done_rsp", u_if.rsp_valid, 0);
        chk("bp_next_ready1", u_if.req1_ready, 1);
        @(posedge clk);
        #1;
        u_if.req1_valid = 1'b0;
        u_if.req1_instr = 12'h788;
        drain();

        // 5: reset during EXEC
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h053;
        @(negedge clk);
        chk("mid_ready0", u_if.req0_ready, 1);
        @(posedge clk);
        #1 u_if.req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_en", u_if.alu_exec_en, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_exec", u_if.alu_exec_en, 0);
        chk("mid_rst_rsp", u_if.rsp_valid, 0);
        chk("mid_rst_alu_b", u_if.alu_b, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", u_if.rsp_valid, 0);
            chk("mid_no_exec", u_if.alu_exec_en, 0);
        end
        @(posedge clk);
        #1;
        u_if.req0_valid = 1'b1;
        u_if.req0_instr = 12'h788;
        u_if.req1_valid = 1'b1;
        u_if.req1_instr = 12'h789;
        @(negedge clk);
        chk("mid_gnt0", u_if.req0_ready, 1);
        chk("mid_gnt1", u_if.req1_ready, 0);
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("end_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
